// File: rtl/x_pattern_serializer.sv
// Parallel-to-serial stimulus source for the machine_d detector: loads a pattern
// and shifts it out LSB first on x, with one-shot or looped playback.
module x_pattern_serializer #(
    parameter int WIDTH = 16,
    localparam int LEN_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             loop_en,
    input  logic             stop,
    output logic             x,
    output logic             busy,
    output logic             ready,
    output logic             done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WIDTH);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_n;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shadow_n;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_n;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] remaining_n;
    logic [LEN_W-1:0] len_in_eff;
    logic             x_n;
    logic             done_n;
    logic             busy_n;

    // Handshake: a start is taken on any rising edge where ready=1, load=1 and
    // stop=0; ready is high exactly when the serializer sits in IDLE.
    assign ready      = (state == IDLE);
    assign len_in_eff = (len == '0 || len > FULL_LEN) ? FULL_LEN : len;

    always_comb begin
        state_n     = state;
        sreg_n      = sreg;
        shadow_n    = shadow;
        len_n       = len_q;
        remaining_n = remaining;
        x_n         = 1'b0;
        done_n      = 1'b0;

        unique case (state)
            IDLE: begin
                if (load && !stop) begin
                    shadow_n    = pattern;
                    len_n       = len_in_eff;
                    x_n         = pattern[0];
                    sreg_n      = pattern >> 1;
                    remaining_n = len_in_eff - 1'b1;
                    state_n     = SHIFT;
                end
            end
            SHIFT: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (remaining != '0) begin
                    x_n         = sreg[0];
                    sreg_n      = sreg >> 1;
                    remaining_n = remaining - 1'b1;
                end else begin
                    // Last bit is on x now; a looped pass restarts with no gap.
                    done_n = 1'b1;
                    if (loop_en) begin
                        x_n         = shadow[0];
                        sreg_n      = shadow >> 1;
                        remaining_n = len_q - 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n == SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sreg      <= '0;
            shadow    <= '0;
            len_q     <= '0;
            remaining <= '0;
            x         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            sreg      <= sreg_n;
            shadow    <= shadow_n;
            len_q     <= len_n;
            remaining <= remaining_n;
            x         <= x_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_x_pattern_serializer.sv
// Directed bench for x_pattern_serializer: one task per scenario, inline
// comparisons against hand-derived bit sequences held in an expected queue.
module tb_x_pattern_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] pattern = '0;
    logic [4:0]  len = '0;
    logic        loop_en = 1'b0;
    logic        stop = 1'b0;
    logic        x;
    logic        busy;
    logic        ready;
    logic        done;

    int          errors = 0;
    int          checks = 0;
    logic [0:0]  exp_q[$];

    x_pattern_serializer #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .pattern (pattern),
        .len     (len),
        .loop_en (loop_en),
        .stop    (stop),
        .x       (x),
        .busy    (busy),
        .ready   (ready),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Drives load for one edge; returns just after that edge, so the next
    // negedge falls in cycle 1 (bit 0 on x).
    task automatic start_load(input logic [15:0] p, input logic [4:0] l, input logic lp);
        @(posedge clk);
        #1;
        pattern = p;
        len     = l;
        loop_en = lp;
        load    = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({x, busy, done, ready} !== 4'b0001) begin
                errors++;
                $display("FAIL reset_hold: x/busy/done/ready=%b expected 0001", {x, busy, done, ready});
            end
        end
        #7 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({x, busy, done, ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_release: x/busy/done/ready=%b expected 0001", {x, busy, done, ready});
        end
    endtask

    task automatic test_one_shot();
        logic [7:0] bits = 8'b1011_0101;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(bits[i]);
        start_load(16'h00B5, 5'd8, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            logic [0:0] e;
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({x, busy, done} !== {e, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL one_shot_c%0d: x/busy/done=%b expected %b", c, {x, busy, done}, {e, 2'b10});
            end
        end
        @(negedge clk);
        checks++;
        if ({x, busy, done, ready} !== 4'b0011) begin
            errors++;
            $display("FAIL one_shot_done: x/busy/done/ready=%b expected 0011", {x, busy, done, ready});
        end
        @(negedge clk);
        checks++;
        if ({done, ready} !== 2'b01) begin
            errors++;
            $display("FAIL one_shot_pulse: done/ready=%b expected 01", {done, ready});
        end
    endtask

    task automatic test_full_length();
        logic [15:0] p = 16'h8001;
        for (int rep = 0; rep < 2; rep++) begin
            exp_q.delete();
            for (int i = 0; i < 16; i++) exp_q.push_back(p[i]);
            exp_q.push_back(1'b0);
            start_load(p, (rep == 0) ? 5'd0 : 5'd20, 1'b0);
            for (int c = 1; c <= 17; c++) begin
                logic [0:0] e;
                @(negedge clk);
                e = exp_q.pop_front();
                checks++;
                if ({x, done} !== {e, (c == 17) ? 1'b1 : 1'b0}) begin
                    errors++;
                    $display("FAIL full_len_r%0d_c%0d: x/done=%b expected %b%b", rep, c, {x, done}, e, (c == 17));
                end
            end
        end
    endtask

    task automatic test_loop();
        logic [2:0] p = 3'b110;
        exp_q.delete();
        for (int c = 1; c <= 10; c++) exp_q.push_back((c <= 9) ? p[(c - 1) % 3] : 1'b0);
        start_load({13'd0, p}, 5'd3, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            logic [0:0] e;
            logic       ed;
            @(negedge clk);
            e  = exp_q.pop_front();
            ed = (c == 4 || c == 7 || c == 10);
            checks++;
            if ({x, done, busy} !== {e, ed, (c <= 9) ? 1'b1 : 1'b0}) begin
                errors++;
                $display("FAIL loop_c%0d: x/done/busy=%b expected %b%b%b", c, {x, done, busy}, e, ed, (c <= 9));
            end
            if (c == 8) loop_en = 1'b0;
        end
        @(negedge clk);
        checks++;
        if ({ready, done} !== 2'b10) begin
            errors++;
            $display("FAIL loop_exit: ready/done=%b expected 10", {ready, done});
        end
    endtask

    task automatic test_stop_abort();
        logic [7:0] bits = 8'hE7;
        exp_q.delete();
        for (int c = 1; c <= 7; c++) exp_q.push_back((c <= 5) ? bits[c - 1] : 1'b0);
        start_load({8'd0, bits}, 5'd8, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            logic [0:0] e;
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({x, busy, done} !== {e, (c <= 5) ? 1'b1 : 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stop_c%0d: x/busy/done=%b expected %b%b0", c, {x, busy, done}, e, (c <= 5));
            end
            load    = (c == 2 || c == 3);
            pattern = 16'h0000;
            len     = 5'd2;
            stop    = (c == 5);
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL stop_idle: ready=%b expected 1", ready);
        end
        // Simultaneous load and stop while idle must not start.
        @(posedge clk);
        #1;
        pattern = 16'hFFFF;
        load    = 1'b1;
        stop    = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        stop = 1'b0;
        @(negedge clk);
        checks++;
        if ({x, busy, ready} !== 3'b001) begin
            errors++;
            $display("FAIL load_stop_idle: x/busy/ready=%b expected 001", {x, busy, ready});
        end
    endtask

    task automatic test_single_bit();
        start_load(16'h0003, 5'd1, 1'b0);
        @(negedge clk);
        checks++;
        if ({x, busy, done} !== 3'b110) begin
            errors++;
            $display("FAIL single_bit: x/busy/done=%b expected 110", {x, busy, done});
        end
        @(negedge clk);
        checks++;
        if ({x, busy, done, ready} !== 4'b0011) begin
            errors++;
            $display("FAIL single_done: x/busy/done/ready=%b expected 0011", {x, busy, done, ready});
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [15:0] p = 16'hA5C3;
        start_load(16'hFFFF, 5'd16, 1'b0);
        repeat (6) @(negedge clk);
        checks++;
        if ({x, busy} !== 2'b11) begin
            errors++;
            $display("FAIL mid_pre: x/busy=%b expected 11", {x, busy});
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({x, busy, done, ready} !== 4'b0001) begin
            errors++;
            $display("FAIL mid_async: x/busy/done/ready=%b expected 0001", {x, busy, done, ready});
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({x, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL mid_after_c%0d: x/busy/done=%b expected 000", c, {x, busy, done});
            end
        end
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(p[i]);
        exp_q.push_back(1'b0);
        start_load(p, 5'd16, 1'b0);
        for (int c = 1; c <= 17; c++) begin
            logic [0:0] e;
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({x, done} !== {e, (c == 17) ? 1'b1 : 1'b0}) begin
                errors++;
                $display("FAIL replay_c%0d: x/done=%b expected %b%b", c, {x, done}, e, (c == 17));
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_full_length();
        test_loop();
        test_stop_abort();
        test_single_bit();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
